// File: rtl/vpu_writeback_unit.sv
// rtl/vpu_writeback_unit.sv - VPU response buffer and element-serial VRF writeback
// Buffers VPU responses, writes them to the VRF one element per cycle, then retires them in order.
package vpu_pkg;
   localparam int MAX_VECTOR_LENGTH = 4;
   localparam int RD_ADDR_W         = 5;

   typedef logic [31:0] word_t;

   typedef struct packed {
      logic                                valid;
      logic [RD_ADDR_W-1:0]                rd_addr;
      logic                                error;
      word_t [MAX_VECTOR_LENGTH-1:0]       result_vector;
   } vpu_rsp_t;
endpackage

module vpu_writeback_unit
   import vpu_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int NUM_ELEMS  = MAX_VECTOR_LENGTH,
   localparam int ELEM_W    = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  vpu_rsp_t             vpu_rsp_i,
   output logic                 vpu_rsp_ready_o,
   input  logic                 flush_i,
   output logic                 vrf_we_o,
   output logic [RD_ADDR_W-1:0] vrf_waddr_o,
   output logic [ELEM_W-1:0]    vrf_elem_idx_o,
   output word_t                vrf_wdata_o,
   input  logic                 vrf_wready_i,
   output logic                 wb_done_o,
   output logic [RD_ADDR_W-1:0] wb_rd_addr_o,
   output logic                 wb_error_o,
   output logic                 overflow_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // The valid bit is implied by occupancy, so only the payload is buffered.
   typedef struct packed {
      logic [RD_ADDR_W-1:0]          rd_addr;
      logic                          error;
      word_t [MAX_VECTOR_LENGTH-1:0] result_vector;
   } entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_e;

   entry_t            mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   entry_t            head;
   entry_t            work_q;
   logic [ELEM_W-1:0] cnt_q;
   state_e            state_q;
   state_e            state_d;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              last_elem;
   logic              overflow_q;

   assign vpu_rsp_ready_o = (count_q < CNT_W'(FIFO_DEPTH));
   assign fifo_empty      = (count_q == '0);
   assign head            = mem_q[rd_ptr_q];
   assign push            = vpu_rsp_i.valid && vpu_rsp_ready_o && !flush_i;
   assign pop             = (state_q == IDLE) && !fifo_empty && !flush_i;
   assign last_elem       = (cnt_q == ELEM_W'(NUM_ELEMS - 1));
   assign overflow_o      = overflow_q;

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{rd_addr:       vpu_rsp_i.rd_addr,
                              error:         vpu_rsp_i.error,
                              result_vector: vpu_rsp_i.result_vector};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (flush_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CNT_W'(1);
         end
         if (vpu_rsp_i.valid && !vpu_rsp_ready_o) begin
            overflow_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         work_q <= '0;
         cnt_q  <= '0;
      end else if (flush_i) begin
         cnt_q  <= '0;
      end else if (pop) begin
         work_q <= head;
         cnt_q  <= '0;
      end else if ((state_q == WRITE) && vrf_wready_i && !last_elem) begin
         cnt_q  <= cnt_q + ELEM_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               // Erroring responses skip the VRF and retire immediately.
               if (!fifo_empty) begin
                  state_d = head.error ? DONE : WRITE;
               end
            end
            WRITE: begin
               if (vrf_wready_i && last_elem) begin
                  state_d = DONE;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      vrf_we_o       = 1'b0;
      vrf_waddr_o    = '0;
      vrf_elem_idx_o = '0;
      vrf_wdata_o    = '0;
      wb_done_o      = 1'b0;
      wb_rd_addr_o   = '0;
      wb_error_o     = 1'b0;
      case (state_q)
         WRITE: begin
            vrf_we_o       = 1'b1;
            vrf_waddr_o    = work_q.rd_addr;
            vrf_elem_idx_o = cnt_q;
            vrf_wdata_o    = work_q.result_vector[cnt_q];
         end
         DONE: begin
            wb_done_o      = 1'b1;
            wb_rd_addr_o   = work_q.rd_addr;
            wb_error_o     = work_q.error;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_vpu_writeback_unit.sv
// tb/tb_vpu_writeback_unit.sv - self-checking bench for vpu_writeback_unit
// Scoreboard of expected VRF writes and retirements plus directed timing checks.
module tb_vpu_writeback_unit;
   import vpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   vpu_rsp_t    rsp;
   logic        ready;
   logic        flush;
   logic        we;
   logic [4:0]  waddr;
   logic [1:0]  idx;
   word_t       wdata;
   logic        wready;
   logic        done;
   logic [4:0]  wbaddr;
   logic        err;
   logic        ovf;

   vpu_writeback_unit #(.FIFO_DEPTH(2), .NUM_ELEMS(4)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .vpu_rsp_i       (rsp),
      .vpu_rsp_ready_o (ready),
      .flush_i         (flush),
      .vrf_we_o        (we),
      .vrf_waddr_o     (waddr),
      .vrf_elem_idx_o  (idx),
      .vrf_wdata_o     (wdata),
      .vrf_wready_i    (wready),
      .wb_done_o       (done),
      .wb_rd_addr_o    (wbaddr),
      .wb_error_o      (err),
      .overflow_o      (ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [4:0] a; logic [1:0] i; word_t d; } wr_t;
   typedef struct { logic [4:0] a; logic e; } dn_t;
   wr_t exp_w[$];
   dn_t exp_d[$];
   int  wr_log[$];
   int  dn_log[$];
   int  errors = 0;
   int  checks = 0;
   int  t0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Compare process: every accepted write and every retirement is matched against the scoreboard.
   logic  prev_stall = 1'b0;
   logic [4:0] p_a;
   logic [1:0] p_i;
   word_t p_d;
   wr_t   cw;
   dn_t   cd;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_we", we, 1);
            chk("stall_addr", waddr, p_a);
            chk("stall_idx", idx, p_i);
            chk("stall_data", wdata, p_d);
         end
         if (we && wready) begin
            wr_log.push_back(cyc);
            if (exp_w.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr=%0d idx=%0d data=%0d, none expected", waddr, idx, wdata);
            end else begin
               cw = exp_w.pop_front();
               chk("write_addr", waddr, cw.a);
               chk("write_idx", idx, cw.i);
               chk("write_data", wdata, cw.d);
            end
         end
         if (done) begin
            dn_log.push_back(cyc);
            if (exp_d.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: rd_addr=%0d error=%0d, none expected", wbaddr, err);
            end else begin
               cd = exp_d.pop_front();
               chk("done_addr", wbaddr, cd.a);
               chk("done_error", err, cd.e);
            end
         end else begin
            chk("err_outside_done", err, 0);
         end
         prev_stall = we && !wready;
         p_a = waddr;
         p_i = idx;
         p_d = wdata;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [4:0] a, input logic e, input word_t [3:0] v, input bit accept);
      wr_t w;
      dn_t d;
      rsp.valid         = 1'b1;
      rsp.rd_addr       = a;
      rsp.error         = e;
      rsp.result_vector = v;
      if (accept) begin
         if (!e) begin
            for (int i = 0; i < 4; i++) begin
               w.a = a;
               w.i = 2'(i);
               w.d = v[i];
               exp_w.push_back(w);
            end
         end
         d.a = a;
         d.e = e;
         exp_d.push_back(d);
      end
   endtask

   task automatic idle();
      rsp.valid = 1'b0;
   endtask

   task automatic clear_logs();
      wr_log.delete();
      dn_log.delete();
   endtask

   task automatic wait_done(input int n, input int budget);
      for (int k = 0; k < budget && dn_log.size() < n; k++) step();
      if (dn_log.size() < n) begin
         checks++;
         errors++;
         $display("FAIL wait_done_timeout: got %0d retirements expected %0d", dn_log.size(), n);
      end
   endtask

   task automatic check_log(input string name, input bit sel_done, input int n,
                            input int e0, input int e1, input int e2, input int e3);
      int q[$];
      int e[4];
      e = '{e0, e1, e2, e3};
      if (sel_done) q = dn_log;
      else          q = wr_log;
      chk({name, "_count"}, q.size(), n);
      for (int i = 0; i < n; i++) begin
         chk({name, "_cycle"}, (i < q.size()) ? q[i] - t0 : -1, e[i]);
      end
   endtask

   task automatic check_drained(input string name);
      chk({name, "_writes_left"}, exp_w.size(), 0);
      chk({name, "_dones_left"}, exp_d.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rsp    = '0;
      flush  = 1'b0;
      wready = 1'b1;
      rst_n  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", ready, 1);
      chk("rst_we", we, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_idx", idx, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_done", done, 0);
      chk("rst_wbaddr", wbaddr, 0);
      chk("rst_err", err, 0);
      chk("rst_ovf", ovf, 0);
      rst_n = 1'b1;
      step();

      // Single response, VRF always ready.
      clear_logs();
      step(); send(5'd5, 1'b0, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b1); t0 = cyc;
      step(); idle();
      wait_done(1, 30);
      check_log("t1_wr", 1'b0, 4, 2, 3, 4, 5);
      check_log("t1_done", 1'b1, 1, 6, 0, 0, 0);
      check_drained("t1");

      // Same response with the VRF stalling in cycles 3-4.
      clear_logs();
      step(); send(5'd5, 1'b0, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b1); t0 = cyc;
      step(); idle();
      step();
      step(); wready = 1'b0;
      step();
      step(); wready = 1'b1;
      wait_done(1, 30);
      check_log("t2_wr", 1'b0, 4, 2, 5, 6, 7);
      check_log("t2_done", 1'b1, 1, 8, 0, 0, 0);
      check_drained("t2");

      // Error response: no writes, retires in cycle 2.
      clear_logs();
      step(); send(5'd9, 1'b1, {32'd0, 32'd0, 32'd0, 32'd0}, 1'b1); t0 = cyc;
      step(); idle();
      wait_done(1, 30);
      check_log("t3_wr", 1'b0, 0, 0, 0, 0, 0);
      check_log("t3_done", 1'b1, 1, 2, 0, 0, 0);
      check_drained("t3");

      // Three back-to-back responses.
      clear_logs();
      step(); send(5'd1, 1'b0, {32'h13, 32'h12, 32'h11, 32'h10}, 1'b1); t0 = cyc;
      chk("t4_ready0", ready, 1);
      step(); send(5'd2, 1'b0, {32'h23, 32'h22, 32'h21, 32'h20}, 1'b1);
      chk("t4_ready1", ready, 1);
      step(); send(5'd3, 1'b0, {32'h33, 32'h32, 32'h31, 32'h30}, 1'b1);
      chk("t4_ready2", ready, 1);
      step(); idle();
      wait_done(3, 60);
      check_log("t4_done", 1'b1, 3, 6, 12, 18, 0);
      chk("t4_ovf", ovf, 0);
      check_drained("t4");

      // Fill the FIFO behind a stalled write, then overflow it.
      clear_logs();
      wready = 1'b0;
      step(); send(5'd4, 1'b0, {32'h43, 32'h42, 32'h41, 32'h40}, 1'b1);
      step(); send(5'd6, 1'b0, {32'h63, 32'h62, 32'h61, 32'h60}, 1'b1);
      step(); send(5'd7, 1'b0, {32'h73, 32'h72, 32'h71, 32'h70}, 1'b1);
      step(); send(5'd8, 1'b0, {32'h83, 32'h82, 32'h81, 32'h80}, 1'b0);
      chk("t5_full_ready", ready, 0);
      chk("t5_ovf_before", ovf, 0);
      step(); idle();
      chk("t5_ovf_set", ovf, 1);
      repeat (5) step();
      chk("t5_ovf_sticky", ovf, 1);
      wready = 1'b1;
      wait_done(3, 80);
      chk("t5_ovf_after_drain", ovf, 1);
      check_drained("t5");

      // Flush during A's element 2 with B buffered.
      clear_logs();
      step(); send(5'd10, 1'b0, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b1); t0 = cyc;
      step(); send(5'd11, 1'b0, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1'b1);
      step(); idle();
      step();
      step(); flush = 1'b1;
      step(); flush = 1'b0;
      exp_w.delete();
      exp_d.delete();
      chk("t6_we_after_flush", we, 0);
      chk("t6_ovf_cleared", ovf, 0);
      chk("t6_ready_empty", ready, 1);
      repeat (20) step();
      check_log("t6_wr", 1'b0, 3, 2, 3, 4, 0);
      chk("t6_no_done", dn_log.size(), 0);
      clear_logs();
      step(); send(5'd12, 1'b0, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 1'b1); t0 = cyc;
      step(); idle();
      wait_done(1, 30);
      check_log("t6_new_wr", 1'b0, 4, 2, 3, 4, 5);
      check_log("t6_new_done", 1'b1, 1, 6, 0, 0, 0);
      check_drained("t6");

      // Reset asserted mid-write drops the write request without a clock edge.
      clear_logs();
      step(); send(5'd13, 1'b0, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 1'b1);
      step(); idle();
      step();
      step();
      chk("t7_we_before_reset", we, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t7_we_async", we, 0);
      chk("t7_done_async", done, 0);
      exp_w.delete();
      exp_d.delete();
      step(); rst_n = 1'b1;
      step();
      chk("t7_ready_after_reset", ready, 1);
      repeat (10) step();
      chk("t7_no_done", dn_log.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
